// File: rtl/gray_pkg.sv
// Shared constants and helpers for the gray-code synchronizer/decoder.
package gray_pkg;

  localparam int unsigned DefWrdLen     = 5;
  localparam int unsigned DefSyncStages = 2;
  // Helpers work on a fixed wide word; callers zero-extend and truncate.
  localparam int unsigned MaxWrdLen     = 32;

  // Gray to binary: b[MSB] = g[MSB], b[k] = b[k+1] ^ g[k].
  function automatic logic [MaxWrdLen-1:0] g2b(input logic [MaxWrdLen-1:0] g);
    logic [MaxWrdLen-1:0] b;
    b[MaxWrdLen-1] = g[MaxWrdLen-1];
    for (int k = MaxWrdLen - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // Number of set bits in v.
  function automatic int unsigned popcount(input logic [MaxWrdLen-1:0] v);
    int unsigned n;
    n = 0;
    for (int k = 0; k < int'(MaxWrdLen); k++) begin
      n += int'(v[k]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational gray-to-binary decode of a WRD_LEN-bit word.
module gray2bin_conv import gray_pkg::*; #(
  parameter int unsigned WRD_LEN = DefWrdLen
) (
  input  logic [WRD_LEN-1:0] gray_i,
  output logic [WRD_LEN-1:0] bin_o
);

  // Zero-extended gray decodes to zero-extended binary, so truncation is exact.
  always_comb begin
    bin_o = WRD_LEN'(g2b(MaxWrdLen'(gray_i)));
  end

endmodule

// File: rtl/gray_sync_decode.sv
// Synchronizes an asynchronous gray-coded count, decodes it to binary and
// reports update pulses, modular advance and illegal multi-bit steps.
module gray_sync_decode import gray_pkg::*; #(
  parameter int unsigned WRD_LEN     = DefWrdLen,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WRD_LEN-1:0] gray_i,
  input  logic               clr_err_i,
  output logic [WRD_LEN-1:0] gray_sync_o,
  output logic [WRD_LEN-1:0] bin_o,
  output logic               upd_o,
  output logic [WRD_LEN-1:0] delta_o,
  output logic               err_o
);

  if (WRD_LEN < 2 || WRD_LEN > MaxWrdLen) begin : g_bad_wrd_len
    $error("gray_sync_decode: WRD_LEN must be in 2..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("gray_sync_decode: SYNC_STAGES must be at least 2");
  end

  logic [WRD_LEN-1:0] r_sync [SYNC_STAGES];
  logic [WRD_LEN-1:0] r_gray_sync;
  logic [WRD_LEN-1:0] r_bin;
  logic               r_upd;
  logic [WRD_LEN-1:0] r_delta;
  logic               r_err;

  logic [WRD_LEN-1:0] w_g_sync;
  logic [WRD_LEN-1:0] w_bin;
  logic [WRD_LEN-1:0] w_delta;
  logic               w_multi_step;

  assign w_g_sync = r_sync[SYNC_STAGES-1];

  gray2bin_conv #(
    .WRD_LEN (WRD_LEN)
  ) u_gray2bin_conv (
    .gray_i (w_g_sync),
    .bin_o  (w_bin)
  );

  // Modular advance and legality of the step from the last registered sample.
  always_comb begin
    w_delta      = w_bin - r_bin;
    w_multi_step = popcount(MaxWrdLen'(w_g_sync ^ r_gray_sync)) > 1;
  end

  // Metastability chain: capture gray_i, shift one stage per edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= gray_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Registered sample, decode, update pulse and advance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gray_sync <= '0;
      r_bin       <= '0;
      r_upd       <= 1'b0;
      r_delta     <= '0;
    end else begin
      r_gray_sync <= w_g_sync;
      r_bin       <= w_bin;
      r_upd       <= (w_g_sync != r_gray_sync);
      r_delta     <= w_delta;
    end
  end

  // Sticky error; a new illegal step outranks a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_multi_step) begin
      r_err <= 1'b1;
    end else if (clr_err_i) begin
      r_err <= 1'b0;
    end
  end

  assign gray_sync_o = r_gray_sync;
  assign bin_o       = r_bin;
  assign upd_o       = r_upd;
  assign delta_o     = r_delta;
  assign err_o       = r_err;

endmodule
